// File: rtl/yarp_pkg.sv
// Shared types for the YARP writeback stage: load metadata and the load data extraction helper.
package yarp_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10
    } ld_size_t;

    typedef struct packed {
        logic [4:0] rd;
        ld_size_t   size;
        logic       is_unsigned;
        logic [1:0] off;
    } ld_meta_t;

    // Misaligned half/word offsets are never issued upstream, so they are not checked here.
    function automatic logic [XLEN-1:0] ld_extract(input ld_meta_t meta, input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] shifted;
        logic            sign;
        shifted    = raw >> {meta.off, 3'b000};
        sign       = 1'b0;
        ld_extract = raw;
        case (meta.size)
            LD_BYTE: begin
                sign       = ~meta.is_unsigned & shifted[7];
                ld_extract = {{(XLEN-8){sign}}, shifted[7:0]};
            end
            LD_HALF: begin
                sign       = ~meta.is_unsigned & shifted[15];
                ld_extract = {{(XLEN-16){sign}}, shifted[15:0]};
            end
            default: ld_extract = raw;
        endcase
    endfunction

endpackage

// File: rtl/yarp_ld_meta_fifo.sv
// In-order metadata FIFO for outstanding loads; every entry is exposed so the
// writeback stage can build its pending-destination scoreboard.
module yarp_ld_meta_fifo
    import yarp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  ld_meta_t         push_meta_i,
    input  logic             pop_i,
    output ld_meta_t         head_o,
    output logic             full_o,
    output logic             empty_o,
    output ld_meta_t         entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    ld_meta_t         mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = &valid_q;
    assign empty_o = ~|valid_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Push and pop never target the same slot: that would need the FIFO to be full or empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q]   <= push_meta_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/yarp_writeback.sv
// YARP writeback stage: merges ALU results and load responses onto the regfile write port.
// Optional macro YARP_WB_ERR_EN adds a sticky wb_err_o for empty-FIFO responses and issues while full.
module yarp_writeback
    import yarp_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            ld_issue_i,
    output logic            ld_issue_ready_o,
    input  logic [4:0]      ld_rd_i,
    input  logic [1:0]      ld_size_i,
    input  logic            ld_unsigned_i,
    input  logic [1:0]      ld_byte_off_i,
    input  logic            ld_rsp_valid_i,
    input  logic [XLEN-1:0] ld_rsp_data_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    output logic [4:0]      rd_addr_o,
    output logic            wr_en_o,
    output logic [XLEN-1:0] wr_data_o
`ifdef YARP_WB_ERR_EN
    ,
    output logic            wb_err_o
`endif
);

    ld_meta_t            push_meta;
    ld_meta_t            head_meta;
    ld_meta_t            fifo_entries [LD_DEPTH];
    logic [LD_DEPTH-1:0] fifo_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic                rsp_take;
    logic                alu_acc;

    logic                skid_valid_q, skid_valid_d;
    logic [4:0]          skid_rd_q, skid_rd_d;
    logic [XLEN-1:0]     skid_data_q, skid_data_d;
    logic                wr_en_q, wr_en_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;

    always_comb begin
        push_meta.rd          = ld_rd_i;
        push_meta.is_unsigned = ld_unsigned_i;
        push_meta.off         = ld_byte_off_i;
        case (ld_size_i)
            2'b00:   push_meta.size = LD_BYTE;
            2'b01:   push_meta.size = LD_HALF;
            default: push_meta.size = LD_WORD;
        endcase
    end

    yarp_ld_meta_fifo #(
        .DEPTH (LD_DEPTH)
    ) u_ld_meta_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (ld_issue_i),
        .push_meta_i (push_meta),
        .pop_i       (rsp_take),
        .head_o      (head_meta),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    assign ld_issue_ready_o = ~fifo_full;
    assign alu_ready_o      = ~skid_valid_q;
    assign alu_acc          = alu_valid_i & alu_ready_o;
    assign rsp_take         = ld_rsp_valid_i & ~fifo_empty;

    // Writes to x0 are consumed but suppressed; rd/data then hold their previous values.
    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_rd_d    = skid_rd_q;
        skid_data_d  = skid_data_q;
        wr_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_data_d    = wr_data_q;
        if (rsp_take) begin
            if (head_meta.rd != 5'd0) begin
                wr_en_d   = 1'b1;
                rd_addr_d = head_meta.rd;
                wr_data_d = ld_extract(head_meta, ld_rsp_data_i);
            end
            if (alu_acc) begin
                skid_valid_d = 1'b1;
                skid_rd_d    = alu_rd_i;
                skid_data_d  = alu_data_i;
            end
        end else if (skid_valid_q) begin
            skid_valid_d = 1'b0;
            if (skid_rd_q != 5'd0) begin
                wr_en_d   = 1'b1;
                rd_addr_d = skid_rd_q;
                wr_data_d = skid_data_q;
            end
        end else if (alu_acc) begin
            if (alu_rd_i != 5'd0) begin
                wr_en_d   = 1'b1;
                rd_addr_d = alu_rd_i;
                wr_data_d = alu_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_rd_q    <= '0;
            skid_data_q  <= '0;
            wr_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_rd_q    <= skid_rd_d;
            skid_data_q  <= skid_data_d;
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_data_o = wr_data_q;

    always_comb begin
        rs1_busy_o = 1'b0;
        rs2_busy_o = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (fifo_valid[i] && fifo_entries[i].rd == rs1_addr_i && rs1_addr_i != 5'd0) begin
                rs1_busy_o = 1'b1;
            end
            if (fifo_valid[i] && fifo_entries[i].rd == rs2_addr_i && rs2_addr_i != 5'd0) begin
                rs2_busy_o = 1'b1;
            end
        end
    end

`ifdef YARP_WB_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (ld_rsp_valid_i & fifo_empty) | (ld_issue_i & fifo_full);
        end
    end

    assign wb_err_o = err_q;
`endif

endmodule

// File: tb/tb_yarp_writeback.sv
// Self-checking bench for yarp_writeback: expected regfile writes are queued as stimulus is driven
// and popped by a monitor whenever the write port fires.
module tb_yarp_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_issue_i;
    logic        ld_issue_ready_o;
    logic [4:0]  ld_rd_i;
    logic [1:0]  ld_size_i;
    logic        ld_unsigned_i;
    logic [1:0]  ld_byte_off_i;
    logic        ld_rsp_valid_i;
    logic [31:0] ld_rsp_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [4:0]  rd_addr_o;
    logic        wr_en_o;
    logic [31:0] wr_data_o;
`ifdef YARP_WB_ERR_EN
    logic        wb_err_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q [$];

    typedef struct {
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] raw;
        logic [31:0] exp;
    } ld_case_t;

    ld_case_t ld_cases [10];

    yarp_writeback #(.LD_DEPTH(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_valid_i      (alu_valid_i),
        .alu_ready_o      (alu_ready_o),
        .alu_rd_i         (alu_rd_i),
        .alu_data_i       (alu_data_i),
        .ld_issue_i       (ld_issue_i),
        .ld_issue_ready_o (ld_issue_ready_o),
        .ld_rd_i          (ld_rd_i),
        .ld_size_i        (ld_size_i),
        .ld_unsigned_i    (ld_unsigned_i),
        .ld_byte_off_i    (ld_byte_off_i),
        .ld_rsp_valid_i   (ld_rsp_valid_i),
        .ld_rsp_data_i    (ld_rsp_data_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rs1_busy_o       (rs1_busy_o),
        .rs2_busy_o       (rs2_busy_o),
        .rd_addr_o        (rd_addr_o),
        .wr_en_o          (wr_en_o),
        .wr_data_o        (wr_data_o)
`ifdef YARP_WB_ERR_EN
        ,
        .wb_err_o         (wb_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [4:0] rd, input logic [31:0] data);
        sb_q.push_back({rd, data});
    endtask

    task automatic drain(input string tag);
        repeat (2) tick();
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] size, input logic uns, input logic [1:0] off);
        ld_issue_i    = 1'b1;
        ld_rd_i       = rd;
        ld_size_i     = size;
        ld_unsigned_i = uns;
        ld_byte_off_i = off;
    endtask

    always @(negedge clk) begin
        if (reset_n && wr_en_o) begin
            if (sb_q.size() == 0) begin
                chk("wr_unexpected_pending", 64'(sb_q.size()), 64'd1);
            end else begin
                chk("wr_rd_data", 64'({rd_addr_o, wr_data_o}), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        ld_cases[0] = '{2'b00, 1'b0, 2'd2, 32'h0080_0000, 32'hFFFF_FF80};
        ld_cases[1] = '{2'b00, 1'b1, 2'd2, 32'h0080_0000, 32'h0000_0080};
        ld_cases[2] = '{2'b01, 1'b0, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
        ld_cases[3] = '{2'b01, 1'b1, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
        ld_cases[4] = '{2'b01, 1'b0, 2'd0, 32'h1234_700D, 32'h0000_700D};
        ld_cases[5] = '{2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        ld_cases[6] = '{2'b11, 1'b1, 2'd0, 32'h8000_0001, 32'h8000_0001};
        ld_cases[7] = '{2'b00, 1'b0, 2'd3, 32'h7F00_0000, 32'h0000_007F};
        ld_cases[8] = '{2'b00, 1'b0, 2'd1, 32'h0000_AB00, 32'hFFFF_FFAB};
        ld_cases[9] = '{2'b00, 1'b1, 2'd0, 32'h0000_00FF, 32'h0000_00FF};

        reset_n        = 1'b0;
        alu_valid_i    = 1'b0;
        alu_rd_i       = '0;
        alu_data_i     = '0;
        ld_issue_i     = 1'b0;
        ld_rd_i        = '0;
        ld_size_i      = '0;
        ld_unsigned_i  = 1'b0;
        ld_byte_off_i  = '0;
        ld_rsp_valid_i = 1'b0;
        ld_rsp_data_i  = '0;
        rs1_addr_i     = '0;
        rs2_addr_i     = '0;

        #12;
        chk("rst_wr_en", 64'(wr_en_o), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_wr_data", 64'(wr_data_o), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rst_issue_ready", 64'(ld_issue_ready_o), 64'd1);
        chk("rst_busy", 64'({rs1_busy_o, rs2_busy_o}), 64'd0);
`ifdef YARP_WB_ERR_EN
        chk("rst_err", 64'(wb_err_o), 64'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // ALU only
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd5;
        alu_data_i  = 32'h1234;
        sb_push(5'd5, 32'h1234);
        tick();
        alu_valid_i = 1'b0;
        chk("alu_ready_held", 64'(alu_ready_o), 64'd1);
        chk("alu_wr_en", 64'(wr_en_o), 64'd1);
        drain("alu_drain");

        // Load extraction table
        for (int i = 0; i < 10; i++) begin
            issue(5'(7 + i), ld_cases[i].size, ld_cases[i].uns, ld_cases[i].off);
            tick();
            ld_issue_i = 1'b0;
            rs1_addr_i = 5'(7 + i);
            #1;
            chk("ld_busy_set", 64'(rs1_busy_o), 64'd1);
            ld_rsp_valid_i = 1'b1;
            ld_rsp_data_i  = ld_cases[i].raw;
            sb_push(5'(7 + i), ld_cases[i].exp);
            tick();
            ld_rsp_valid_i = 1'b0;
            chk("ld_busy_clr", 64'(rs1_busy_o), 64'd0);
        end
        drain("ld_drain");

        // ALU and load response collide
        issue(5'd4, 2'b10, 1'b0, 2'd0);
        tick();
        ld_issue_i     = 1'b0;
        alu_valid_i    = 1'b1;
        alu_rd_i       = 5'd3;
        alu_data_i     = 32'hAA;
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h55;
        sb_push(5'd4, 32'h55);
        sb_push(5'd3, 32'hAA);
        tick();
        alu_valid_i    = 1'b0;
        ld_rsp_valid_i = 1'b0;
        chk("coll_ready_c1", 64'(alu_ready_o), 64'd0);
        chk("coll_rd_c1", 64'(rd_addr_o), 64'd4);
        tick();
        chk("coll_ready_c2", 64'(alu_ready_o), 64'd1);
        chk("coll_rd_c2", 64'(rd_addr_o), 64'd3);
        drain("coll_drain");

        // x0 targets and response with empty FIFO
        alu_valid_i = 1'b1;
        alu_rd_i    = 5'd0;
        alu_data_i  = 32'hBEEF;
        tick();
        alu_valid_i = 1'b0;
        chk("x0_alu_wr_en", 64'(wr_en_o), 64'd0);
        chk("x0_alu_ready", 64'(alu_ready_o), 64'd1);
        issue(5'd0, 2'b10, 1'b0, 2'd0);
        tick();
        ld_issue_i = 1'b0;
        rs1_addr_i = 5'd0;
        #1;
        chk("x0_busy", 64'(rs1_busy_o), 64'd0);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h1111;
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("x0_ld_wr_en", 64'(wr_en_o), 64'd0);
        issue(5'd17, 2'b10, 1'b0, 2'd0);
        tick();
        ld_issue_i     = 1'b0;
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h1717;
        sb_push(5'd17, 32'h1717);
        tick();
        ld_rsp_valid_i = 1'b0;
        drain("x0_drain");
`ifdef YARP_WB_ERR_EN
        chk("err_before_empty_rsp", 64'(wb_err_o), 64'd0);
`endif
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h9999;
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("empty_rsp_wr_en", 64'(wr_en_o), 64'd0);
`ifdef YARP_WB_ERR_EN
        chk("err_set", 64'(wb_err_o), 64'd1);
        tick();
        chk("err_sticky", 64'(wb_err_o), 64'd1);
`endif

        // Scoreboard and full FIFO
        issue(5'd9, 2'b10, 1'b0, 2'd0);
        tick();
        tick();
        ld_issue_i = 1'b0;
        rs1_addr_i = 5'd9;
        rs2_addr_i = 5'd5;
        #1;
        chk("full_issue_ready", 64'(ld_issue_ready_o), 64'd0);
        chk("full_rs1_busy", 64'(rs1_busy_o), 64'd1);
        chk("full_rs2_not_busy", 64'(rs2_busy_o), 64'd0);
        issue(5'd12, 2'b10, 1'b0, 2'd0);
        tick();
        ld_issue_i = 1'b0;
        rs2_addr_i = 5'd12;
        #1;
        chk("drop_busy", 64'(rs2_busy_o), 64'd0);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h11;
        sb_push(5'd9, 32'h11);
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("dup_still_busy", 64'(rs1_busy_o), 64'd1);
        chk("dup_issue_ready", 64'(ld_issue_ready_o), 64'd1);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h22;
        sb_push(5'd9, 32'h22);
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("dup_busy_clr", 64'(rs1_busy_o), 64'd0);
        chk("drop_no_entry", 64'(ld_issue_ready_o), 64'd1);
        drain("full_drain");

        // Simultaneous push and pop
        issue(5'd10, 2'b10, 1'b0, 2'd0);
        tick();
        issue(5'd11, 2'b10, 1'b0, 2'd0);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h33;
        sb_push(5'd10, 32'h33);
        tick();
        ld_issue_i     = 1'b0;
        ld_rsp_valid_i = 1'b0;
        rs1_addr_i     = 5'd10;
        rs2_addr_i     = 5'd11;
        #1;
        chk("pp_rs1_clr", 64'(rs1_busy_o), 64'd0);
        chk("pp_rs2_busy", 64'(rs2_busy_o), 64'd1);
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h44;
        sb_push(5'd11, 32'h44);
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("pp_rs2_clr", 64'(rs2_busy_o), 64'd0);
        drain("pp_drain");

        // Async reset with skid full and one load pending
        issue(5'd13, 2'b10, 1'b0, 2'd0);
        tick();
        issue(5'd14, 2'b10, 1'b0, 2'd0);
        tick();
        ld_issue_i     = 1'b0;
        alu_valid_i    = 1'b1;
        alu_rd_i       = 5'd15;
        alu_data_i     = 32'hF15;
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h1313;
        sb_push(5'd13, 32'h1313);
        tick();
        alu_valid_i    = 1'b0;
        ld_rsp_valid_i = 1'b0;
        rs1_addr_i     = 5'd14;
        chk("arst_skid_full", 64'(alu_ready_o), 64'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(wr_en_o), 64'd0);
        chk("arst_rd_addr", 64'(rd_addr_o), 64'd0);
        chk("arst_wr_data", 64'(wr_data_o), 64'd0);
        chk("arst_busy", 64'(rs1_busy_o), 64'd0);
        chk("arst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("arst_issue_ready", 64'(ld_issue_ready_o), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        ld_rsp_valid_i = 1'b1;
        ld_rsp_data_i  = 32'h1414;
        tick();
        ld_rsp_valid_i = 1'b0;
        chk("late_rsp_wr_en", 64'(wr_en_o), 64'd0);
        tick();
        chk("no_skid_wr_en", 64'(wr_en_o), 64'd0);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
